mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH_I, default 32, operand width in bits (range 2..64).
REQ-002 SHALL have parameter DATA_WIDTH_O, default 64, result width in bits (range DATA_WIDTH_I..128).
REQ-003 SHALL have parameter LATENCY, default 3, pipeline stages from accepted input to valid output (range 1..8).
REQ-004 SHALL have parameter SIGNED, default 0, where 1 selects two's-complement operands and 0 selects unsigned operands.
REQ-005 SHALL have port clk, input, 1 bit, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have ports a and b, input, DATA_WIDTH_I bits each, operands.
REQ-008 SHALL have port valid, input, 1 bit, operand beat present.
REQ-009 SHALL have port ready, output, 1 bit, block accepts a beat this cycle.
REQ-010 SHALL have port res, output, DATA_WIDTH_O bits, result.
REQ-011 SHALL have port res_valid, output, 1 bit, res holds a result.
REQ-012 SHALL have port res_ready, input, 1 bit, downstream accepts res this cycle.
REQ-013 SHALL have port busy, output, 1 bit, high while any pipeline stage holds a valid beat.
REQ-014 SHALL have port acc_clr, input, 1 bit, restart accumulation with this beat; present only when MUL_PIPE_ACC_EN is defined.

Function
REQ-015 SHALL accept an input beat on any cycle with valid=1 and ready=1, and SHALL complete an output beat on any cycle with res_valid=1 and res_ready=1.
REQ-016 SHALL derive advance = !res_valid || res_ready and SHALL drive ready = advance combinationally.
REQ-017 SHALL shift all stages and their valid bits by one on each advance=1 cycle, and SHALL hold every stage, including bubbles, when advance=0.
REQ-018 SHALL present a beat accepted at cycle t on res with res_valid=1 at cycle t+LATENCY when res_ready is held at 1.
REQ-019 SHALL sustain one beat per cycle under continuous valid=1 and res_ready=1.
REQ-020 SHALL keep res and res_valid stable while res_valid=1 and res_ready=0.
REQ-021 SHALL compute the full 2*DATA_WIDTH_I product.
REQ-022 SHALL truncate the product to its low DATA_WIDTH_O bits when DATA_WIDTH_O < 2*DATA_WIDTH_I.
REQ-023 SHALL extend the product when DATA_WIDTH_O > 2*DATA_WIDTH_I, using sign extension when SIGNED=1 and zero extension when SIGNED=0.
REQ-024 SHALL accept and complete a beat in the same cycle when res_valid=1, res_ready=1 and valid=1, with no bubble inserted.
REQ-025 SHALL ignore a and b whenever valid=0, and SHALL NOT modify the pipeline from such a cycle beyond shifting a bubble.
REQ-026 SHALL drive busy as the OR of all stage valid bits, including the output stage.

Reset
REQ-027 SHALL clear all stage valid bits, res_valid, busy and the accumulator on a cycle with rst=1.
REQ-028 SHALL drive res to 0 during and immediately after reset.
REQ-029 SHALL discard in-flight beats when reset is asserted mid-operation, and SHALL NOT emit them afterwards.
REQ-030 SHALL drive ready=1 on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL compile in the accumulate feature when macro MUL_PIPE_ACC_EN is defined.
REQ-032 With MUL_PIPE_ACC_EN defined, SHALL set res = acc + product (modulo 2^DATA_WIDTH_O) and update acc to that value at the output stage, in acceptance order.
REQ-033 With MUL_PIPE_ACC_EN defined, SHALL give a beat accepted with acc_clr=1 the result res = product and restart acc from it.
REQ-034 With MUL_PIPE_ACC_EN defined, SHALL leave acc unchanged while the output stage is stalled.
REQ-035 Without MUL_PIPE_ACC_EN, SHALL omit the acc_clr port and accumulator and drive res = product.

Verification
REQ-036 SHALL verify: defaults, SIGNED=0, a=0xFFFFFFFF, b=2, res_ready=1 -> res=0x00000001FFFFFFFE exactly 3 cycles after acceptance.
REQ-037 SHALL verify: SIGNED=1, a=0xFFFFFFFF (-1), b=5 -> res=0xFFFFFFFFFFFFFFFB.
REQ-038 SHALL verify: 10 back-to-back beats with res_ready=0 for cycles 4..7 -> ready low during the stall, all 10 results delivered in order, none lost or duplicated.
REQ-039 SHALL verify: rst=1 for one cycle with 2 beats in flight -> res_valid=0 and busy=0 the next cycle, and no stale result later.
REQ-040 SHALL verify: MUL_PIPE_ACC_EN defined, beats (3,4,acc_clr=1), (2,5,0), (1,1,0) -> res = 12, 22, 23.
REQ-041 SHALL verify: DATA_WIDTH_I=8, DATA_WIDTH_O=8, a=0x10, b=0x11 -> res=0x10 (truncated).

Source files
------------

// File: rtl/mul_pipe_if.sv
// mul_pipe_if: operand/result bus for mul_pipe.
// Handshake: a beat moves on a cycle where its valid and its ready are both 1
// at the rising edge (valid/ready for operands, res_valid/res_ready for
// results). A producer holds its payload and valid steady until accepted.
// acc_clr exists only when MUL_PIPE_ACC_EN is defined.
interface mul_pipe_if #(
   parameter int DATA_WIDTH_I = 32,
   parameter int DATA_WIDTH_O = 64
) ();
   logic [DATA_WIDTH_I-1:0] a;
   logic [DATA_WIDTH_I-1:0] b;
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH_O-1:0] res;
   logic                    res_valid;
   logic                    res_ready;
   logic                    busy;
`ifdef MUL_PIPE_ACC_EN
   logic                    acc_clr;
`endif

   modport master (
`ifdef MUL_PIPE_ACC_EN
      output acc_clr,
`endif
      output a, b, valid, res_ready,
      input  ready, res, res_valid, busy
   );

   modport slave (
`ifdef MUL_PIPE_ACC_EN
      input  acc_clr,
`endif
      input  a, b, valid, res_ready,
      output ready, res, res_valid, busy
   );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: LATENCY-stage pipelined multiplier with valid/ready flow control.
// The whole pipe advances together whenever the output stage is empty or its
// result is being taken; otherwise every stage, bubbles included, holds.
// Optional feature macro MUL_PIPE_ACC_EN: adds acc_clr and a running
// accumulator applied at the output stage (res = acc + product).
module mul_pipe #(
   parameter int DATA_WIDTH_I = 32,
   parameter int DATA_WIDTH_O = 64,
   parameter int LATENCY      = 3,
   parameter int SIGNED       = 0
) (
   input  logic      clk,
   input  logic      rst,
   mul_pipe_if.slave bus
);

   logic                    w_advance;
   logic [DATA_WIDTH_O-1:0] w_ax;
   logic [DATA_WIDTH_O-1:0] w_bx;
   logic [DATA_WIDTH_O-1:0] w_prod;
   logic [DATA_WIDTH_O-1:0] w_stage0_d;
   logic                    w_last_vld;
   logic [DATA_WIDTH_O-1:0] w_last_in;
   logic [DATA_WIDTH_O-1:0] w_last_d;

   logic [LATENCY-1:0]      r_vld;
   logic [DATA_WIDTH_O-1:0] r_data [LATENCY];

   // Extend operands to the result width (sign or zero). Only the low
   // DATA_WIDTH_O bits of the full product are ever kept, and those equal the
   // product of the extended operands taken modulo 2^DATA_WIDTH_O, which also
   // yields the sign/zero extension when the result is wider than 2*width.
   always_comb begin
      w_ax = '0;
      w_bx = '0;
      w_ax[DATA_WIDTH_I-1:0] = bus.a;
      w_bx[DATA_WIDTH_I-1:0] = bus.b;
      for (int i = DATA_WIDTH_I; i < DATA_WIDTH_O; i++) begin
         w_ax[i] = (SIGNED != 0) && bus.a[DATA_WIDTH_I-1];
         w_bx[i] = (SIGNED != 0) && bus.b[DATA_WIDTH_I-1];
      end
   end

   assign w_prod     = w_ax * w_bx;
   // Bubbles carry zero so operand values on idle cycles never enter the pipe.
   assign w_stage0_d = bus.valid ? w_prod : '0;

   assign w_advance     = !r_vld[LATENCY-1] || bus.res_ready;
   assign bus.ready     = w_advance;
   assign bus.res_valid = r_vld[LATENCY-1];
   assign bus.res       = r_data[LATENCY-1];
   assign bus.busy      = |r_vld;

`ifdef MUL_PIPE_ACC_EN
   localparam int CW = (LATENCY > 1) ? LATENCY - 1 : 1;
   logic [CW-1:0]           r_clr;
   logic [DATA_WIDTH_O-1:0] r_acc;
   logic                    w_last_clr;
`endif

   // Select what feeds the output stage: the input itself for a 1-deep pipe,
   // otherwise the stage just before the output.
   generate
      if (LATENCY == 1) begin : g_last_from_input
         assign w_last_vld = bus.valid;
         assign w_last_in  = w_stage0_d;
`ifdef MUL_PIPE_ACC_EN
         assign w_last_clr = bus.acc_clr;
`endif
      end else begin : g_last_from_stage
         assign w_last_vld = r_vld[LATENCY-2];
         assign w_last_in  = r_data[LATENCY-2];
`ifdef MUL_PIPE_ACC_EN
         assign w_last_clr = r_clr[CW-1];
`endif
      end
   endgenerate

`ifdef MUL_PIPE_ACC_EN
   // Output-stage value: restart from the product on acc_clr, else add to acc.
   always_comb begin
      w_last_d = '0;
      if (w_last_vld) begin
         w_last_d = w_last_clr ? w_last_in : (r_acc + w_last_in);
      end
   end
`else
   assign w_last_d = w_last_in;
`endif

   // Pipeline shift: every stage moves one step on advance, all hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            r_data[k] <= '0;
         end
`ifdef MUL_PIPE_ACC_EN
         r_clr <= '0;
         r_acc <= '0;
`endif
      end else if (w_advance) begin
         for (int k = LATENCY - 1; k > 0; k--) begin
            r_vld[k]  <= r_vld[k-1];
            r_data[k] <= (k == LATENCY - 1) ? w_last_d : r_data[k-1];
         end
         r_vld[0]  <= bus.valid;
         r_data[0] <= (LATENCY == 1) ? w_last_d : w_stage0_d;
`ifdef MUL_PIPE_ACC_EN
         if (LATENCY > 1) begin
            r_clr[0] <= bus.valid & bus.acc_clr;
            for (int k = 1; k < CW; k++) begin
               r_clr[k] <= r_clr[k-1];
            end
         end
         if (w_last_vld) begin
            r_acc <= w_last_d;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: scoreboard bench for mul_pipe. Three instances share one
// stimulus stream: unsigned 32x32->64, signed 32x32->64 and unsigned 8x8->8.
// Build with MUL_PIPE_ACC_EN defined to exercise the accumulator.
module tb_mul_pipe;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] drv_a, drv_b;
   logic        drv_valid, drv_res_ready, drv_clr;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out_m = 0;
   bit done_rand;

   logic [63:0] q_m[$];
   logic [63:0] q_s[$];
   logic [7:0]  q_t[$];
   logic [63:0] acc_m, acc_s;
   logic [7:0]  acc_t;
   logic [63:0] p_m, p_s;
   logic [7:0]  p_t;

   always #5 clk = ~clk;

   mul_pipe_if #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(64)) if_m ();
   mul_pipe_if #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(64)) if_s ();
   mul_pipe_if #(.DATA_WIDTH_I(8),  .DATA_WIDTH_O(8))  if_t ();

   assign if_m.a = drv_a;        assign if_m.b = drv_b;
   assign if_s.a = drv_a;        assign if_s.b = drv_b;
   assign if_t.a = drv_a[7:0];   assign if_t.b = drv_b[7:0];
   assign if_m.valid = drv_valid;  assign if_m.res_ready = drv_res_ready;
   assign if_s.valid = drv_valid;  assign if_s.res_ready = drv_res_ready;
   assign if_t.valid = drv_valid;  assign if_t.res_ready = drv_res_ready;
`ifdef MUL_PIPE_ACC_EN
   assign if_m.acc_clr = drv_clr;
   assign if_s.acc_clr = drv_clr;
   assign if_t.acc_clr = drv_clr;
`endif

   mul_pipe #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(64), .LATENCY(LAT), .SIGNED(0))
      u_m (.clk(clk), .rst(rst), .bus(if_m));
   mul_pipe #(.DATA_WIDTH_I(32), .DATA_WIDTH_O(64), .LATENCY(LAT), .SIGNED(1))
      u_s (.clk(clk), .rst(rst), .bus(if_s));
   mul_pipe #(.DATA_WIDTH_I(8), .DATA_WIDTH_O(8), .LATENCY(LAT), .SIGNED(0))
      u_t (.clk(clk), .rst(rst), .bus(if_t));

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference arithmetic: plain integer products.
   function automatic logic [63:0] ref_u(input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua = a, ub = b;
      return 64'(ua * ub);
   endfunction

   function automatic logic [63:0] ref_s(input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'(signed'(a));
      longint sb = longint'(signed'(b));
      return 64'(sa * sb);
   endfunction

   function automatic logic [7:0] ref_t(input logic [7:0] a, input logic [7:0] b);
      int unsigned p = int'(a) * int'(b);
      return 8'(p % 256);
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   // Scoreboard feed: every accepted beat pushes its expected result.
   always @(negedge clk) begin
      if (!rst && drv_valid) begin
         if (if_m.ready) begin
            p_m = ref_u(drv_a, drv_b);
`ifdef MUL_PIPE_ACC_EN
            acc_m = drv_clr ? p_m : acc_m + p_m;
            p_m = acc_m;
`endif
            q_m.push_back(p_m);
         end
         if (if_s.ready) begin
            p_s = ref_s(drv_a, drv_b);
`ifdef MUL_PIPE_ACC_EN
            acc_s = drv_clr ? p_s : acc_s + p_s;
            p_s = acc_s;
`endif
            q_s.push_back(p_s);
         end
         if (if_t.ready) begin
            p_t = ref_t(drv_a[7:0], drv_b[7:0]);
`ifdef MUL_PIPE_ACC_EN
            acc_t = drv_clr ? p_t : 8'(acc_t + p_t);
            p_t = acc_t;
`endif
            q_t.push_back(p_t);
         end
      end
   end

   // Monitors: pop on each completed output beat; check hold during stalls.
   logic        hold_m, hold_s, hold_t;
   logic [63:0] prev_m, prev_s;
   logic [7:0]  prev_t;

   always @(negedge clk) begin
      if (rst) begin
         hold_m = 1'b0;
      end else begin
         if (hold_m) begin
            chk("hold_valid_u", if_m.res_valid, 1);
            chk("hold_res_u", if_m.res, prev_m);
         end
         if (if_m.res_valid && if_m.res_ready) begin
            if (q_m.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_u: got 0x%0h expected no result", if_m.res);
            end else begin
               chk("res_u", if_m.res, q_m.pop_front());
               n_out_m++;
            end
         end
         hold_m = if_m.res_valid && !if_m.res_ready;
         prev_m = if_m.res;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hold_s = 1'b0;
      end else begin
         if (hold_s) begin
            chk("hold_res_s", if_s.res, prev_s);
         end
         if (if_s.res_valid && if_s.res_ready) begin
            if (q_s.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_s: got 0x%0h expected no result", if_s.res);
            end else begin
               chk("res_s", if_s.res, q_s.pop_front());
            end
         end
         hold_s = if_s.res_valid && !if_s.res_ready;
         prev_s = if_s.res;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         hold_t = 1'b0;
      end else begin
         if (hold_t) begin
            chk("hold_res_t", if_t.res, prev_t);
         end
         if (if_t.res_valid && if_t.res_ready) begin
            if (q_t.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL extra_t: got 0x%0h expected no result", if_t.res);
            end else begin
               chk("res_t", if_t.res, q_t.pop_front());
            end
         end
         hold_t = if_t.res_valid && !if_t.res_ready;
         prev_t = if_t.res;
      end
   end

   // Driver tasks: called at posedge+1, return at posedge+1.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic clr);
      int  waited = 0;
      logic ok;
      drv_a = a; drv_b = b; drv_clr = clr; drv_valid = 1'b1;
      forever begin
         @(negedge clk);
         ok = if_m.ready;
         @(posedge clk);
         #1;
         if (ok) break;
         waited++;
         if (waited > 100) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: ready stayed 0 for %0d cycles", waited);
            break;
         end
      end
      drv_valid = 1'b0;
      drv_a = $urandom();
      drv_b = $urandom();
      drv_clr = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv_valid = 1'b0;
      q_m.delete(); q_s.delete(); q_t.delete();
      acc_m = '0; acc_s = '0; acc_t = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int w;
      int base;
      drv_valid = 1'b0; drv_res_ready = 1'b1; drv_a = '0; drv_b = '0; drv_clr = 1'b0;
      acc_m = '0; acc_s = '0; acc_t = '0;
      hold_m = 1'b0; hold_s = 1'b0; hold_t = 1'b0;

      // Reset state, during and just after reset.
      @(posedge clk);
      @(negedge clk);
      chk("rst_res_valid", if_m.res_valid, 0);
      chk("rst_busy", if_m.busy, 0);
      chk("rst_res", if_m.res, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", if_m.ready, 1);
      chk("post_rst_res_valid", if_m.res_valid, 0);
      chk("post_rst_res", if_m.res, 0);
      @(posedge clk);
      #1;

      // Exact latency and corner products.
      send(32'hFFFF_FFFF, 32'h2, 1'b1);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("latency_valid", if_m.res_valid, (k == LAT));
         if (k == LAT) begin
            chk("max_x2_u", if_m.res, 64'h0000_0001_FFFF_FFFE);
         end else begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      send(32'hFFFF_FFFF, 32'h5, 1'b1);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == LAT) chk("minus1_x5_s", if_s.res, 64'hFFFF_FFFF_FFFF_FFFB);
         @(posedge clk);
         #1;
      end
      send(32'h10, 32'h11, 1'b1);
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         if (k == LAT) chk("trunc_t", if_t.res, 8'h10);
         @(posedge clk);
         #1;
      end
`ifdef MUL_PIPE_ACC_EN
      send(32'd3, 32'd4, 1'b1);
      send(32'd2, 32'd5, 1'b0);
      send(32'd1, 32'd1, 1'b0);
      @(negedge clk);
      chk("acc_first", if_m.res, 64'd12);
      @(posedge clk); #1;
      @(negedge clk);
      chk("acc_second", if_m.res, 64'd22);
      @(posedge clk); #1;
      @(negedge clk);
      chk("acc_third", if_m.res, 64'd23);
      @(posedge clk); #1;
`endif
      idle(LAT + 2);

      // Ten back-to-back beats with the output stalled on cycles 4..7.
      base = n_out_m;
      fork
         begin
            for (int i = 0; i < 10; i++) send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
         end
         begin
            for (int c = 0; c < 12; c++) begin
               drv_res_ready = !(c >= 4 && c <= 7);
               @(negedge clk);
               if (c >= 4 && c <= 7) chk("stall_ready", if_m.ready, 0);
               @(posedge clk);
               #1;
            end
            drv_res_ready = 1'b1;
         end
      join
      idle(LAT + 4);
      chk("stall_count", n_out_m - base, 10);

      // Reset with two beats in flight: they must vanish.
      send(pick_operand(), pick_operand(), 1'b1);
      send(pick_operand(), pick_operand(), 1'b1);
      do_reset();
      @(negedge clk);
      chk("midrst_res_valid", if_m.res_valid, 0);
      chk("midrst_busy", if_m.busy, 0);
      for (int k = 0; k < LAT + 3; k++) begin
         @(negedge clk);
         chk("midrst_quiet_busy", if_m.busy, 0);
      end
      @(posedge clk);
      #1;
      send(pick_operand(), pick_operand(), 1'b0);
      idle(LAT + 2);

      // Randomized traffic with random gaps and random back-pressure.
      done_rand = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               idle($urandom_range(0, 2));
               send(pick_operand(), pick_operand(), ($urandom_range(0, 7) == 0));
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               drv_res_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            drv_res_ready = 1'b1;
         end
      join

      w = 0;
      while ((q_m.size() + q_s.size() + q_t.size()) != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain_left", q_m.size() + q_s.size() + q_t.size(), 0);
      @(negedge clk);
      chk("end_busy", if_m.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
